// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone frame generator and its sine ROM, and the
// tone identifier width that the tone detector also uses.
//   TONE_ID_W  : width of a tone identifier (0 = silence, 1..7 = tones)
//   LUT_ADDR_W : address width of the quarter-folded 64-entry sine ROM
//   SAMPLE_W   : width of one signed real or imaginary sample
//   TONE_INC   : phase increment per sample for each tone identifier
// ---------------------------------------------------------------------------
package tone_pkg;

   localparam int TONE_ID_W  = 3;
   localparam int LUT_ADDR_W = 6;
   localparam int SAMPLE_W   = 16;

   // Two-state frame controller: waiting for a request, or streaming a frame.
   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } tone_state_e;

   // Tone k advances the phase by 512*k per sample. With a 16-bit phase and a
   // 1024-sample frame this lands tone k exactly on FFT bin 8k.
   localparam logic [31:0] TONE_INC [0:7] = '{
      32'd0, 32'd512, 32'd1024, 32'd1536,
      32'd2048, 32'd2560, 32'd3072, 32'd3584
   };

endpackage

// File: rtl/sine_lut.sv
// ---------------------------------------------------------------------------
// sine_lut
// 64-entry combinational sine ROM, one full period, amplitude 32767.
// Only the first quarter wave (17 entries) is stored; the other three
// quarters are produced by mirroring the index and negating the result.
// Ports:
//   i_addr   : table index 0..63 (angle = 2*pi*i_addr/64)
//   o_sample : round(32767*sin(angle)), two's-complement signed
// ---------------------------------------------------------------------------
module sine_lut
   import tone_pkg::*;
(
   input  logic [LUT_ADDR_W-1:0]      i_addr,
   output logic signed [SAMPLE_W-1:0] o_sample
);

   logic [1:0]          w_quadrant;
   logic [3:0]          w_offset;
   logic [4:0]          w_qIndex;
   logic [SAMPLE_W-1:0] w_magnitude;

   assign w_quadrant = i_addr[5:4];
   assign w_offset   = i_addr[3:0];

   // Odd quadrants run the quarter wave backwards, so index 16 (the peak)
   // is reached when the offset is zero.
   assign w_qIndex = w_quadrant[0] ? (5'd16 - {1'b0, w_offset}) : {1'b0, w_offset};

   // Quarter-wave magnitudes, round(32767*sin(2*pi*k/64)) for k = 0..16.
   always_comb begin
      w_magnitude = '0;
      case (w_qIndex)
         5'd0:    w_magnitude = 16'd0;
         5'd1:    w_magnitude = 16'd3212;
         5'd2:    w_magnitude = 16'd6393;
         5'd3:    w_magnitude = 16'd9512;
         5'd4:    w_magnitude = 16'd12539;
         5'd5:    w_magnitude = 16'd15446;
         5'd6:    w_magnitude = 16'd18204;
         5'd7:    w_magnitude = 16'd20787;
         5'd8:    w_magnitude = 16'd23170;
         5'd9:    w_magnitude = 16'd25329;
         5'd10:   w_magnitude = 16'd27245;
         5'd11:   w_magnitude = 16'd28898;
         5'd12:   w_magnitude = 16'd30273;
         5'd13:   w_magnitude = 16'd31356;
         5'd14:   w_magnitude = 16'd32137;
         5'd15:   w_magnitude = 16'd32609;
         5'd16:   w_magnitude = 16'd32767;
         default: w_magnitude = '0;
      endcase
   end

   // The second half of the period is the negated first half.
   assign o_sample = w_quadrant[1] ? -$signed(w_magnitude) : $signed(w_magnitude);

endmodule

// File: rtl/tone_frame_generator.sv
// ---------------------------------------------------------------------------
// tone_frame_generator
// Accepts a tone identifier and emits one frame of FRAME_LEN complex samples
// {cos, sin} of that tone, for driving the FFT / tone detector chain.
// Parameters:
//   FRAME_LEN : samples per frame (power of two, 16..4096)
//   PHASE_W   : phase accumulator width, wraps modulo 2^PHASE_W
// Ports:
//   clk_in           : clock, rising edge
//   rst_in           : asynchronous reset, active low
//   tone_valid_in    : tone request valid
//   tone_ident_in    : requested tone, 0 = silence, 1..7 = tones
//   tone_ready_out   : high while idle, a request can be accepted
//   sample_data_out  : {real[31:16], imag[15:0]}, signed
//   sample_valid_out : sample_data_out holds a sample of the frame
//   sample_last_out  : final sample of the frame
//   sample_ready_in  : downstream takes the sample
// ---------------------------------------------------------------------------
module tone_frame_generator
   import tone_pkg::*;
#(
   parameter int FRAME_LEN = 1024,
   parameter int PHASE_W   = 16
)
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 tone_valid_in,
   input  logic [TONE_ID_W-1:0] tone_ident_in,
   output logic                 tone_ready_out,
   output logic [31:0]          sample_data_out,
   output logic                 sample_valid_out,
   output logic                 sample_last_out,
   input  logic                 sample_ready_in
);

   localparam int IDX_W = $clog2(FRAME_LEN);

   localparam logic [0:0] S_IDLE   = 1'(ST_IDLE);
   localparam logic [0:0] S_STREAM = 1'(ST_STREAM);

   logic [0:0]           r_state;
   logic [TONE_ID_W-1:0] r_tone;
   logic [PHASE_W-1:0]   r_phase;
   logic [IDX_W-1:0]     r_index;
   logic [31:0]          r_data;

   logic                   w_accept;
   logic                   w_advance;
   logic                   w_finalIdx;
   logic [TONE_ID_W-1:0]   w_nextTone;
   logic [PHASE_W-1:0]     w_nextPhase;
   logic [LUT_ADDR_W-1:0]  w_sinAddr;
   logic [LUT_ADDR_W-1:0]  w_cosAddr;
   logic signed [SAMPLE_W-1:0] w_sin;
   logic signed [SAMPLE_W-1:0] w_cos;
   logic [31:0]            w_nextData;

   assign w_accept   = (r_state == S_IDLE) && tone_valid_in;
   assign w_advance  = (r_state == S_STREAM) && sample_ready_in;
   assign w_finalIdx = (r_index == IDX_W'(FRAME_LEN - 1));

   // The sample register is always loaded one step ahead: on acceptance it
   // gets sample 0 of the new tone, on each handshake the following sample.
   assign w_nextTone  = w_accept ? tone_ident_in : r_tone;
   assign w_nextPhase = w_accept ? '0 : (r_phase + PHASE_W'(TONE_INC[r_tone]));

   // Cosine is the sine a quarter period ahead; the 6-bit add wraps mod 64.
   assign w_sinAddr = w_nextPhase[PHASE_W-1 -: LUT_ADDR_W];
   assign w_cosAddr = w_sinAddr + LUT_ADDR_W'(16);

   sine_lut u_sinTap (
      .i_addr   (w_sinAddr),
      .o_sample (w_sin)
   );

   sine_lut u_cosTap (
      .i_addr   (w_cosAddr),
      .o_sample (w_cos)
   );

   assign w_nextData = (w_nextTone == '0) ? 32'h0000_0000 : {w_cos, w_sin};

   // Frame controller. A request is only taken while idle; once streaming,
   // registers only move on a sample handshake, which keeps data and last
   // stable through downstream stalls. The final handshake drops back to
   // idle, so the next request can be taken on the following edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= S_IDLE;
         r_tone  <= '0;
         r_phase <= '0;
         r_index <= '0;
         r_data  <= '0;
      end else if (w_accept) begin
         r_state <= S_STREAM;
         r_tone  <= tone_ident_in;
         r_phase <= '0;
         r_index <= '0;
         r_data  <= w_nextData;
      end else if (w_advance) begin
         if (w_finalIdx) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_index <= '0;
            r_data  <= '0;
         end else begin
            r_phase <= w_nextPhase;
            r_index <= r_index + IDX_W'(1);
            r_data  <= w_nextData;
         end
      end
   end

   assign tone_ready_out   = (r_state == S_IDLE);
   assign sample_valid_out = (r_state == S_STREAM);
   assign sample_last_out  = sample_valid_out && w_finalIdx;
   assign sample_data_out  = r_data;

endmodule

// File: tb/tb_tone_frame_generator.sv
// ---------------------------------------------------------------------------
// tb_tone_frame_generator
// Self-checking bench for tone_frame_generator. Expected samples come from a
// floating-point sine reference evaluated per sample index; random sample
// backpressure and random don't-care request identifiers are applied.
// ---------------------------------------------------------------------------
module tb_tone_frame_generator;

   localparam int FRAME_LEN = 1024;
   localparam int BUDGET    = 16 * FRAME_LEN;

   logic        clk_in;
   logic        rst_in;
   logic        tone_valid_in;
   logic [2:0]  tone_ident_in;
   logic        tone_ready_out;
   logic [31:0] sample_data_out;
   logic        sample_valid_out;
   logic        sample_last_out;
   logic        sample_ready_in;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] capData [FRAME_LEN];
   logic [31:0] refRun  [FRAME_LEN];

   int   stValid, stLast, stDataErr, stLastErr, stStallErr, stDrop, stReadyHigh, stTimeout;
   logic stPostReady, stPostValid, stPostLast;

   tone_frame_generator #(
      .FRAME_LEN (FRAME_LEN),
      .PHASE_W   (16)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .tone_valid_in    (tone_valid_in),
      .tone_ident_in    (tone_ident_in),
      .tone_ready_out   (tone_ready_out),
      .sample_data_out  (sample_data_out),
      .sample_valid_out (sample_valid_out),
      .sample_last_out  (sample_last_out),
      .sample_ready_in  (sample_ready_in)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // round(32767*sin(2*pi*k/64)), rounding half away from zero.
   function automatic int refSin(input int k);
      real x;
      x = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
      if (x >= 0.0) return $rtoi(x + 0.5);
      else return -$rtoi(-x + 0.5);
   endfunction

   // Sample idx of a tone frame: the phase after idx steps of 512*tone,
   // top six bits select the angle, real part is cosine, imag part is sine.
   function automatic logic [31:0] refSample(input int tone, input int idx);
      int          phase;
      int          addr;
      logic [15:0] s;
      logic [15:0] c;
      if (tone == 0) return 32'h0000_0000;
      phase = (idx * 512 * tone) % 65536;
      addr  = phase / 1024;
      s     = 16'(refSin(addr));
      c     = 16'(refSin((addr + 16) % 64));
      return {c, s};
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present a tone request for one cycle while idle; returns on the falling
   // edge right after the accepting edge, with the identifier scrambled.
   task automatic applyStimulus(input int tone);
      @(negedge clk_in);
      checkOutput("ready_before_request", 32'(tone_ready_out), 32'd1);
      tone_valid_in = 1'b1;
      tone_ident_in = 3'(tone);
      @(negedge clk_in);
      tone_valid_in = 1'b0;
      tone_ident_in = 3'($urandom_range(7, 0));
   endtask

   // Walk one frame from the current falling edge, collecting statistics
   // against the reference and capturing every handshaken sample.
   task automatic captureFrame(input int tone, input int readyPct);
      int          idx;
      int          cyc;
      logic        prevStall;
      logic [31:0] prevData;
      logic        prevLast;
      idx = 0; cyc = 0; prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
      stValid = 0; stLast = 0; stDataErr = 0; stLastErr = 0;
      stStallErr = 0; stDrop = 0; stReadyHigh = 0;
      while (idx < FRAME_LEN && cyc < BUDGET) begin
         if (!sample_valid_out) begin
            stDrop++;
         end else begin
            stValid++;
            if (prevStall && (sample_data_out !== prevData || sample_last_out !== prevLast))
               stStallErr++;
            if (sample_data_out !== refSample(tone, idx)) stDataErr++;
            if (sample_last_out !== (idx == FRAME_LEN - 1)) stLastErr++;
         end
         if (tone_ready_out) stReadyHigh++;
         sample_ready_in = (int'($urandom_range(99, 0)) < readyPct);
         if (sample_valid_out && sample_ready_in) begin
            capData[idx] = sample_data_out;
            if (sample_last_out) stLast++;
            idx++;
            prevStall = 1'b0;
         end else begin
            prevStall = sample_valid_out;
         end
         prevData = sample_data_out;
         prevLast = sample_last_out;
         cyc++;
         @(negedge clk_in);
      end
      stTimeout   = (idx < FRAME_LEN) ? 1 : 0;
      stPostReady = tone_ready_out;
      stPostValid = sample_valid_out;
      stPostLast  = sample_last_out;
   endtask

   task automatic reportFrame(input string name, input bit stalled);
      checkOutput({name, "_timeout"},      32'(stTimeout),   32'd0);
      checkOutput({name, "_data_errs"},    32'(stDataErr),   32'd0);
      checkOutput({name, "_last_errs"},    32'(stLastErr),   32'd0);
      checkOutput({name, "_last_count"},   32'(stLast),      32'd1);
      checkOutput({name, "_valid_drops"},  32'(stDrop),      32'd0);
      checkOutput({name, "_ready_in_frame"}, 32'(stReadyHigh), 32'd0);
      checkOutput({name, "_stall_errs"},   32'(stStallErr),  32'd0);
      checkOutput({name, "_post_ready"},   32'(stPostReady), 32'd1);
      checkOutput({name, "_post_valid"},   32'(stPostValid), 32'd0);
      checkOutput({name, "_post_last"},    32'(stPostLast),  32'd0);
      if (!stalled) checkOutput({name, "_valid_cycles"}, 32'(stValid), 32'(FRAME_LEN));
   endtask

   initial begin
      int diffs;
      int edges;
      int acceptEdge;
      int heldErrs;
      int heldReady;
      int tone;
      int pct;

      rst_in          = 1'b0;
      tone_valid_in   = 1'b0;
      tone_ident_in   = 3'd0;
      sample_ready_in = 1'b0;

      // Reset values are visible before any clock edge.
      #1;
      checkOutput("reset_ready", 32'(tone_ready_out),   32'd1);
      checkOutput("reset_valid", 32'(sample_valid_out), 32'd0);
      checkOutput("reset_last",  32'(sample_last_out),  32'd0);
      checkOutput("reset_data",  sample_data_out,       32'h0);
      @(negedge clk_in);
      rst_in = 1'b1;
      sample_ready_in = 1'b1;

      // Tone 1, no backpressure.
      applyStimulus(1);
      captureFrame(1, 100);
      checkOutput("t1_sample0", capData[0], 32'h7FFF_0000);
      checkOutput("t1_sample2", capData[2], 32'h7F61_0C8C);
      reportFrame("t1", 1'b0);

      // Silence: zero data, full-length frame.
      applyStimulus(0);
      captureFrame(0, 100);
      reportFrame("t0", 1'b0);

      // Tone 3 without and with random backpressure must capture identically.
      applyStimulus(3);
      captureFrame(3, 100);
      reportFrame("t3", 1'b0);
      for (int i = 0; i < FRAME_LEN; i++) refRun[i] = capData[i];
      applyStimulus(3);
      captureFrame(3, 50);
      reportFrame("t3stall", 1'b1);
      diffs = 0;
      for (int i = 0; i < FRAME_LEN; i++) if (capData[i] !== refRun[i]) diffs++;
      checkOutput("t3_stall_vs_nostall", 32'(diffs), 32'd0);

      // Tone 5 request held through a tone 2 frame.
      @(negedge clk_in);
      tone_valid_in   = 1'b1;
      tone_ident_in   = 3'd2;
      sample_ready_in = 1'b1;
      @(negedge clk_in);
      tone_ident_in = 3'd5;
      edges = 0; acceptEdge = -1; heldErrs = 0; heldReady = 0;
      while (acceptEdge < 0 && edges < BUDGET) begin
         if (tone_ready_out) begin
            acceptEdge = edges + 1;
         end else begin
            if (edges < FRAME_LEN) begin
               if (sample_data_out !== refSample(2, edges)) heldErrs++;
            end else begin
               heldReady++;
            end
            @(negedge clk_in);
            edges++;
         end
      end
      checkOutput("held_accept_edge", 32'(acceptEdge), 32'(FRAME_LEN + 1));
      checkOutput("held_t2_data_errs", 32'(heldErrs), 32'd0);
      checkOutput("held_late_ready", 32'(heldReady), 32'd0);
      @(negedge clk_in);
      tone_valid_in = 1'b0;
      captureFrame(5, 100);
      reportFrame("held5", 1'b0);

      // Asynchronous reset in the middle of a tone 6 frame.
      applyStimulus(6);
      sample_ready_in = 1'b1;
      repeat (500) @(negedge clk_in);
      checkOutput("pre_reset_sample500", sample_data_out, refSample(6, 500));
      #2;
      rst_in = 1'b0;
      #1;
      checkOutput("async_reset_ready", 32'(tone_ready_out),   32'd1);
      checkOutput("async_reset_valid", 32'(sample_valid_out), 32'd0);
      checkOutput("async_reset_last",  32'(sample_last_out),  32'd0);
      checkOutput("async_reset_data",  sample_data_out,       32'h0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      applyStimulus(4);
      captureFrame(4, 100);
      checkOutput("t4_sample0", capData[0], 32'h7FFF_0000);
      reportFrame("t4", 1'b0);

      // Random tones under random backpressure.
      for (int r = 0; r < 2; r++) begin
         tone = int'($urandom_range(7, 1));
         pct  = int'($urandom_range(90, 30));
         applyStimulus(tone);
         captureFrame(tone, pct);
         reportFrame("rand", 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tone_frame_generator.md
# tone_frame_generator

Transmit-side counterpart of the tone detector. Accepts a 3-bit tone identifier through a ready/valid handshake. Emits exactly one frame of FRAME_LEN complex samples on a ready/valid/last stream, in the same 32-bit {real, imag} format the detector consumes. Sits ahead of the FFT, as the stimulus source or loopback transmitter for tone-detection tests.

## Interface
- FRAME_LEN, 1024: samples per frame; power of two, 16..4096.
- PHASE_W, 16: phase accumulator width; wraps modulo 2^PHASE_W.
- clk_in  input  1: single clock, all logic on rising edge.
- rst_in  input  1: asynchronous, active-low reset.
- tone_valid_in  input  1: tone request valid.
- tone_ident_in  input  3: tone to send; 0 = silence, 1..7 = tones.
- tone_ready_out  output  1: generator can accept a request.
- sample_data_out  output  32: {real[31:16], imag[15:0]}, both two's-complement signed.
- sample_valid_out  output  1: sample_data_out is valid.
- sample_last_out  output  1: marks the final sample of a frame.
- sample_ready_in  input  1: downstream accepts the sample.

## Operation
- States: IDLE, STREAM.
- IDLE:
  - tone_ready_out=1, sample_valid_out=0.
  - On tone_valid_in && tone_ready_out: latch tone_ident_in, clear phase and sample index to 0, load the first sample register, go to STREAM.
- STREAM:
  - tone_ready_out=0, sample_valid_out=1.
  - On sample_valid_out && sample_ready_in: index++ and phase += TONE_INC[tone], then load the next sample.
  - The handshake with index==FRAME_LEN-1 returns the block to IDLE.
- Sample generation:
  - LUT address = phase[PHASE_W-1 -: 6].
  - imag = SIN_LUT[addr]; real = SIN_LUT[(addr+16) mod 64], i.e. cosine.
  - SIN_LUT[k] = round(32767*sin(2πk/64)), signed 16-bit.
  - Tone 0 forces data to 32'h0000_0000; the frame length is unchanged.
- TONE_INC[k] = 512*k for k=1..7, giving FFT bin 8k for a 1024-point frame with PHASE_W=16.
- Phase wrap is natural modulo arithmetic. No saturation is needed; LUT values never exceed ±32767.
- sample_last_out = 1 exactly while sample_valid_out=1 and index==FRAME_LEN-1; otherwise 0.
- A request arriving during STREAM is not accepted: ready is low, and the requester must hold it until IDLE.
- Reset: takes effect asynchronously at any time, including mid-frame. The frame is abandoned with no trailing last.
  - Reset values: tone_ready_out=1, sample_valid_out=0, sample_last_out=0, sample_data_out=0.
  - Internal state after reset: state=IDLE, phase=0, index=0.

## Timing
- Request accepted on edge N → sample 0 valid from edge N+1. No bubble between samples while sample_ready_in stays high.
- Full frame with no backpressure: FRAME_LEN cycles of valid. tone_ready_out rises on the edge after the last handshake.
- Minimum request-to-request period is FRAME_LEN+1 cycles.
- While sample_valid_out=1 and sample_ready_in=0, data, valid and last hold stable (stream rule). Valid never drops mid-frame.
- sample_ready_in may be high in IDLE; it has no effect there.
- tone_ident_in is sampled only on the accepting edge. Later changes do not affect the current frame.

## Structure
- Package tone_pkg holds:
  - the state enum;
  - TONE_INC[0:7];
  - LUT_ADDR_W=6;
  - SAMPLE_W=16;
  - the tone_ident width (3). The detector shares this width.
- Sub-module sine_lut: 64×16 combinational ROM, address in, signed sample out. It is instantiated twice (sin and cos taps), or once with two read ports.
- All output registers stay in the top module.

## Test plan
- Reset, then tone 1, sample_ready_in=1:
  - sample 0 = 32'h7FFF_0000, sample 2 = 32'h7F61_0C8C.
  - Exactly 1024 valid cycles; last only on sample 1023; tone_ready_out=1 on the following cycle.
- Tone 0: 1024 samples all 32'h0000_0000, last on sample 1023.
- Tone 3 with random sample_ready_in (50%):
  - data/last stable across every stall;
  - captured sequence identical to the no-stall run;
  - exactly one last per frame.
- Request tone 5 held while STREAM for tone 2:
  - not accepted until IDLE;
  - the second frame starts with phase 0 at edge FRAME_LEN+1 after the first accept.
- Assert rst_in low at sample 500:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - after release, a new tone 4 frame starts with sample 0 = 32'h7FFF_0000.
- Loopback: generator into the FFT and tone detector for tones 1..7 → the detector reports the matching tone_ident for each.
